// File: rtl/library_pkg.sv
// Shared constants and width helpers for the buffering library blocks.
// Consumed by sync_fifo and its pointer sub-module.
package library_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_DEPTH    = 8;
    localparam int DEFAULT_AF_LEVEL = 6;

    // Pointer width for a power-of-two DEPTH. Pointers wrap naturally modulo DEPTH.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count needs one extra bit so that it can represent DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// fifo_ptr: wrapping pointer counter with an enable and a synchronous clear.
// The clear input has priority over the enable.
module fifo_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;
    logic [W-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (en) begin
            ptr_next = ptr_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with registered read data and status flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo
    import library_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEFAULT_AF_LEVEL
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     we,
    input  logic                     re,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] data_out_reg;
    logic             push_acc;
    logic             pop_acc;

    // Acceptance is decided on the current state only, so a push while full is
    // rejected even when a pop frees a slot on the same edge.
    assign push_acc = we & ~full;
    assign pop_acc  = re & ~empty;

    fifo_ptr #(.W(PW)) u_wp (
        .clk (clk),
        .clr (reset),
        .en  (push_acc),
        .ptr (wp)
    );

    fifo_ptr #(.W(PW)) u_rp (
        .clk (clk),
        .clr (reset),
        .en  (pop_acc),
        .ptr (rp)
    );

    // Storage is left uncleared on reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push_acc && !reset) begin
            mem[wp] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg <= '0;
        end else if (pop_acc) begin
            data_out_reg <= mem[rp];
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push_acc, pop_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign data_out    = data_out_reg;
    assign count       = count_reg;
    assign full        = (count_reg == CW'(DEPTH));
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg >= CW'(AF_LEVEL));

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_reg  | (we & full);
            underflow_reg <= underflow_reg | (re & empty);
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (WIDTH=8, DEPTH=8, AF_LEVEL=6): a directed
// vector table followed by randomized traffic checked against a queue model.
module tb_sync_fifo;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             we;
    logic             re;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [3:0]       count;
`ifdef SYNC_FIFO_ERR_EN
    logic             overflow;
    logic             underflow;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .we          (we),
        .re          (re),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    // Behavioural model: a plain queue plus the last popped word.
    int               m_q[$];
    logic [WIDTH-1:0] m_dout = '0;
    bit               m_ovf  = 1'b0;
    bit               m_unf  = 1'b0;

    typedef struct {
        logic             rst;
        logic             w;
        logic             r;
        logic [WIDTH-1:0] din;
        int               cnt;
        logic [WIDTH-1:0] dout;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic rst, input logic w, input logic r,
                                input int din, input int cnt, input int dout);
        vec_t v;
        v.rst  = rst;
        v.w    = w;
        v.r    = r;
        v.din  = WIDTH'(din);
        v.cnt  = cnt;
        v.dout = WIDTH'(dout);
        vt.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // Applies one cycle of stimulus and advances the model on the same edge.
    task automatic step(input logic r_in, input logic w_in, input logic rd_in,
                        input logic [WIDTH-1:0] d_in);
        bit was_full;
        bit was_empty;
        reset   = r_in;
        we      = w_in;
        re      = rd_in;
        data_in = d_in;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (r_in) begin
            m_q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            if (w_in && was_full)   m_ovf = 1'b1;
            if (rd_in && was_empty) m_unf = 1'b1;
            if (rd_in && !was_empty) m_dout = WIDTH'(m_q.pop_front());
            if (w_in && !was_full)   m_q.push_back(int'(d_in));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_err(input int idx);
`ifdef SYNC_FIFO_ERR_EN
        chk("overflow",  idx, int'(overflow),  int'(m_ovf));
        chk("underflow", idx, int'(underflow), int'(m_unf));
`else
        if (idx < 0) $display("unused %0d", idx);
`endif
    endtask

    initial begin
        reset   = 1'b1;
        we      = 1'b0;
        re      = 1'b0;
        data_in = '0;

        // Directed table, expected values written from the FIFO rules.
        add(1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 1, 0, k, k, 0);
        add(0, 1, 0, 9, 8, 0);                            // push while full dropped
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 8 - k, k);
        add(0, 0, 1, 0, 0, 8);                            // pop while empty holds
        add(0, 1, 0, 'h11, 1, 8);
        add(0, 1, 0, 'h22, 2, 8);
        add(0, 1, 0, 'h33, 3, 8);
        add(0, 1, 1, 'hA0, 3, 'h11);
        add(0, 1, 1, 'hA1, 3, 'h22);
        add(0, 1, 1, 'hA2, 3, 'h33);
        for (int k = 3; k <= 9; k++) add(0, 1, 1, 'hA0 + k, 3, 'hA0 + k - 3);
        add(0, 0, 1, 0, 2, 'hA7);
        add(0, 0, 1, 0, 1, 'hA8);
        add(0, 0, 1, 0, 0, 'hA9);
        add(0, 1, 1, 'h55, 1, 'hA9);                      // empty + we/re: push only
        for (int k = 0; k < 7; k++) add(0, 1, 0, 'h60 + k, 2 + k, 'hA9);
        add(0, 1, 1, 'h77, 7, 'h55);                      // full + we/re: pop only
        add(0, 0, 1, 0, 6, 'h60);
        add(0, 0, 1, 0, 5, 'h61);
        add(1, 1, 0, 'h99, 0, 0);                         // reset beats push
        add(0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 'h42, 1, 0);
        add(0, 0, 1, 0, 0, 'h42);                         // one-cycle write-to-read

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].rst, vt[i].w, vt[i].r, vt[i].din);
            chk("count", i, int'(count), vt[i].cnt);
            chk("empty", i, int'(empty), int'(vt[i].cnt == 0));
            chk("full",  i, int'(full),  int'(vt[i].cnt == DEPTH));
            chk("almost_full", i, int'(almost_full), int'(vt[i].cnt >= AF_LEVEL));
            chk("data_out", i, int'(data_out), int'(vt[i].dout));
            chk_err(i);
            $display("vec %0d rst=%0b we=%0b re=%0b din=%02h -> count=%0d dout=%02h",
                     i, vt[i].rst, vt[i].w, vt[i].r, vt[i].din, count, data_out);
        end

        // Error-flag corner: overflow and underflow both recorded, then reset clears.
        for (int k = 0; k < DEPTH; k++) step(0, 1, 0, WIDTH'(k));
        step(0, 1, 0, 8'hEE);
        chk_err(1000);
        for (int k = 0; k < DEPTH; k++) step(0, 0, 1, '0);
        step(0, 0, 1, '0);
        chk("drain_hold", 1001, int'(data_out), DEPTH - 1);
        chk_err(1001);
        step(1, 0, 0, '0);
        chk_err(1002);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic r_r, w_r, rd_r;
            logic [WIDTH-1:0] d_r;
            r_r  = ($urandom_range(0, 79) == 0);
            w_r  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
            rd_r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
            d_r  = WIDTH'($urandom);
            step(r_r, w_r, rd_r, d_r);
            chk("rnd_count", i, int'(count), m_q.size());
            chk("rnd_empty", i, int'(empty), int'(m_q.size() == 0));
            chk("rnd_full",  i, int'(full),  int'(m_q.size() == DEPTH));
            chk("rnd_af",    i, int'(almost_full), int'(m_q.size() >= AF_LEVEL));
            chk("rnd_dout",  i, int'(data_out), int'(m_dout));
            chk_err(i);
            $display("rnd %0d rst=%0b we=%0b re=%0b din=%02h -> count=%0d dout=%02h",
                     i, r_r, w_r, rd_r, d_r, count, data_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
